// File: rtl/seg7_scan_driver_pkg.sv
// Shared segment patterns (active-high, gfedcba) and idle constants for the
// 4-digit scan driver; the single source of the hex decode table.
package seg7_scan_driver_pkg;

  localparam logic [6:0] SEG_HEX_0 = 7'h3F;
  localparam logic [6:0] SEG_HEX_1 = 7'h06;
  localparam logic [6:0] SEG_HEX_2 = 7'h5B;
  localparam logic [6:0] SEG_HEX_3 = 7'h4F;
  localparam logic [6:0] SEG_HEX_4 = 7'h66;
  localparam logic [6:0] SEG_HEX_5 = 7'h6D;
  localparam logic [6:0] SEG_HEX_6 = 7'h7D;
  localparam logic [6:0] SEG_HEX_7 = 7'h07;
  localparam logic [6:0] SEG_HEX_8 = 7'h7F;
  localparam logic [6:0] SEG_HEX_9 = 7'h6F;
  localparam logic [6:0] SEG_HEX_A = 7'h77;
  localparam logic [6:0] SEG_HEX_B = 7'h7C;
  localparam logic [6:0] SEG_HEX_C = 7'h39;
  localparam logic [6:0] SEG_HEX_D = 7'h5E;
  localparam logic [6:0] SEG_HEX_E = 7'h79;
  localparam logic [6:0] SEG_HEX_F = 7'h71;

  // Idle levels in active-high sense; polarity is applied at the output register.
  localparam logic [6:0] SEG_OFF = 7'h00;
  localparam logic [3:0] AN_OFF  = 4'h0;
  localparam logic       DP_OFF  = 1'b0;

endpackage

// File: rtl/seg7_scan_driver_hex_to_seg7.sv
// Combinational hex nibble to 7-segment pattern (active-high, gfedcba).
module hex_to_seg7
  import seg7_scan_driver_pkg::*;
(
  input  logic [3:0] nibble,
  output logic [6:0] seg
);

  always_comb begin
    seg = SEG_OFF;
    unique case (nibble)
      4'h0: seg = SEG_HEX_0;
      4'h1: seg = SEG_HEX_1;
      4'h2: seg = SEG_HEX_2;
      4'h3: seg = SEG_HEX_3;
      4'h4: seg = SEG_HEX_4;
      4'h5: seg = SEG_HEX_5;
      4'h6: seg = SEG_HEX_6;
      4'h7: seg = SEG_HEX_7;
      4'h8: seg = SEG_HEX_8;
      4'h9: seg = SEG_HEX_9;
      4'hA: seg = SEG_HEX_A;
      4'hB: seg = SEG_HEX_B;
      4'hC: seg = SEG_HEX_C;
      4'hD: seg = SEG_HEX_D;
      4'hE: seg = SEG_HEX_E;
      4'hF: seg = SEG_HEX_F;
    endcase
  end

endmodule

// File: rtl/seg7_scan_driver.sv
// Time-multiplexed 4-digit 7-segment driver: per-frame snapshot of the display
// bus, per-slot ghost-suppression blank, registered polarity-adjusted outputs.
module seg7_scan_driver
  import seg7_scan_driver_pkg::*;
#(
  parameter int unsigned CLK_DIV      = 50000,
  parameter int unsigned BLANK_CYCLES = 500,
  parameter bit          ACTIVE_LOW   = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] data,
  input  logic [3:0]  dot,
  output logic [3:0]  an,
  output logic [6:0]  seg,
  output logic        dp
);

  localparam int unsigned    DW       = $clog2(CLK_DIV);
  localparam logic [DW-1:0]  DIV_LAST = DW'(CLK_DIV - 1);
  localparam logic [3:0]     AN_IDLE  = AN_OFF ^ {4{ACTIVE_LOW}};
  localparam logic [6:0]     SEG_IDLE = SEG_OFF ^ {7{ACTIVE_LOW}};
  localparam logic           DP_IDLE  = DP_OFF ^ ACTIVE_LOW;

  logic [DW-1:0] div_cnt_q, div_cnt_d;
  logic [1:0]    digit_q, digit_d;
  logic [15:0]   shadow_data_q, shadow_data_d;
  logic [3:0]    shadow_dot_q, shadow_dot_d;
  logic          load_pend_q, load_pend_d;
  logic [3:0]    an_q, an_d;
  logic [6:0]    seg_q, seg_d;
  logic          dp_q, dp_d;

  logic          slot_end;
  logic          load;
  logic          blank;
  logic [3:0]    nibble;
  logic [6:0]    seg_pat;

  always_ff @(posedge clk) begin
    if (rst) begin
      div_cnt_q     <= '0;
      digit_q       <= '0;
      shadow_data_q <= '0;
      shadow_dot_q  <= '0;
      load_pend_q   <= 1'b1;
      an_q          <= AN_IDLE;
      seg_q         <= SEG_IDLE;
      dp_q          <= DP_IDLE;
    end else begin
      div_cnt_q     <= div_cnt_d;
      digit_q       <= digit_d;
      shadow_data_q <= shadow_data_d;
      shadow_dot_q  <= shadow_dot_d;
      load_pend_q   <= load_pend_d;
      an_q          <= an_d;
      seg_q         <= seg_d;
      dp_q          <= dp_d;
    end
  end

  // Snapshot happens right after reset and on the last cycle of digit 3, so a
  // whole frame is always drawn from one bus value.
  always_comb begin
    slot_end      = (div_cnt_q == DIV_LAST);
    load          = load_pend_q || (slot_end && (digit_q == 2'd3));
    div_cnt_d     = slot_end ? '0 : div_cnt_q + DW'(1);
    digit_d       = slot_end ? digit_q + 2'd1 : digit_q;
    shadow_data_d = load ? data : shadow_data_q;
    shadow_dot_d  = load ? dot : shadow_dot_q;
    load_pend_d   = 1'b0;
  end

  if (BLANK_CYCLES == 0) begin : g_noblank
    always_comb blank = 1'b0;
  end else begin : g_blank
    always_comb blank = (32'(div_cnt_q) < BLANK_CYCLES);
  end

  always_comb nibble = shadow_data_q[{digit_q, 2'b00} +: 4];

  hex_to_seg7 u_dec (
    .nibble (nibble),
    .seg    (seg_pat)
  );

  always_comb begin
    an_d  = (blank ? AN_OFF : (4'b0001 << digit_q)) ^ {4{ACTIVE_LOW}};
    seg_d = seg_pat ^ {7{ACTIVE_LOW}};
    dp_d  = shadow_dot_q[digit_q] ^ ACTIVE_LOW;
  end

  assign an  = an_q;
  assign seg = seg_q;
  assign dp  = dp_q;

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Directed bench for seg7_scan_driver: table-driven frames plus reset,
// anti-tear, polarity and random-frame sequences.
module tb_seg7_scan_driver;

  logic        clk = 1'b0;
  logic        rst, rst2;
  logic [15:0] data, data2;
  logic [3:0]  dot, dot2;
  logic [3:0]  an, an2;
  logic [6:0]  seg, seg2;
  logic        dp, dp2;

  int total = 0;
  int bad   = 0;
  bit chk_en = 1'b0;

  typedef struct {
    logic [15:0] data;
    logic [3:0]  dot;
    logic [27:0] seg;   // {digit3, digit2, digit1, digit0}, active-low
    logic [3:0]  dp;    // active-low
  } vec_t;

  vec_t       tbl [18];
  logic [6:0] lut_al [16];

  always #5 clk = ~clk;

  seg7_scan_driver #(.CLK_DIV(8), .BLANK_CYCLES(2), .ACTIVE_LOW(1'b1)) dut (
    .clk(clk), .rst(rst), .data(data), .dot(dot), .an(an), .seg(seg), .dp(dp)
  );

  seg7_scan_driver #(.CLK_DIV(8), .BLANK_CYCLES(0), .ACTIVE_LOW(1'b0)) dut2 (
    .clk(clk), .rst(rst2), .data(data2), .dot(dot2), .an(an2), .seg(seg2), .dp(dp2)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Checks frame cycles start..stop of dut; ndata/ndot are driven from cycle chg.
  task automatic run_frame(input int start, input int stop, input logic [27:0] eseg,
                           input logic [3:0] edp, input logic [15:0] ndata,
                           input logic [3:0] ndot, input int chg);
    for (int j = start; j <= stop; j++) begin
      int dg;
      logic [3:0] oh;
      if (j == chg) begin
        data = ndata;
        dot  = ndot;
      end
      tick();
      dg = j / 8;
      oh = 4'b0001 << dg;
      chk("an",  {28'd0, an},  {28'd0, ((j % 8) < 2) ? 4'hF : ~oh});
      chk("seg", {25'd0, seg}, {25'd0, eseg[7*dg +: 7]});
      chk("dp",  {31'd0, dp},  {31'd0, edp[dg]});
    end
  endtask

  function automatic logic [27:0] exp_seg(input logic [15:0] d);
    return {lut_al[d[15:12]], lut_al[d[11:8]], lut_al[d[7:4]], lut_al[d[3:0]]};
  endfunction

  always @(negedge clk) begin
    if (chk_en) begin
      chk("one_hot_an",  {31'd0, ($countones(~an) > 1)}, 32'd0);
      chk("one_hot_an2", {31'd0, ($countones(an2) > 1)}, 32'd0);
    end
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [15:0] cur_d, nxt_d;
    logic [3:0]  cur_p, nxt_p;

    lut_al = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
               7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};
    tbl[0]  = '{16'h1234, 4'b0101, {7'h79, 7'h24, 7'h30, 7'h19}, 4'b1010};
    tbl[1]  = '{16'hABCD, 4'b0101, {7'h08, 7'h03, 7'h46, 7'h21}, 4'b1010};
    tbl[2]  = '{16'h0000, 4'b0000, {4{7'h40}}, 4'b1111};
    tbl[3]  = '{16'h1111, 4'b0001, {4{7'h79}}, 4'b1110};
    tbl[4]  = '{16'h2222, 4'b0010, {4{7'h24}}, 4'b1101};
    tbl[5]  = '{16'h3333, 4'b0011, {4{7'h30}}, 4'b1100};
    tbl[6]  = '{16'h4444, 4'b0100, {4{7'h19}}, 4'b1011};
    tbl[7]  = '{16'h5555, 4'b0101, {4{7'h12}}, 4'b1010};
    tbl[8]  = '{16'h6666, 4'b0110, {4{7'h02}}, 4'b1001};
    tbl[9]  = '{16'h7777, 4'b0111, {4{7'h78}}, 4'b1000};
    tbl[10] = '{16'h8888, 4'b1000, {4{7'h00}}, 4'b0111};
    tbl[11] = '{16'h9999, 4'b1001, {4{7'h10}}, 4'b0110};
    tbl[12] = '{16'hAAAA, 4'b1010, {4{7'h08}}, 4'b0101};
    tbl[13] = '{16'hBBBB, 4'b1011, {4{7'h03}}, 4'b0100};
    tbl[14] = '{16'hCCCC, 4'b1100, {4{7'h46}}, 4'b0011};
    tbl[15] = '{16'hDDDD, 4'b1101, {4{7'h21}}, 4'b0010};
    tbl[16] = '{16'hEEEE, 4'b1110, {4{7'h06}}, 4'b0001};
    tbl[17] = '{16'hFFFF, 4'b1111, {4{7'h0E}}, 4'b0000};

    // Reset with a live bus value: outputs must stay inactive
    rst = 1'b1; data = 16'h1234; dot = 4'b0101;
    rst2 = 1'b1; data2 = 16'h8888; dot2 = 4'hF;
    repeat (3) begin
      tick();
      chk("rst_an",  {28'd0, an},  32'hF);
      chk("rst_seg", {25'd0, seg}, 32'h7F);
      chk("rst_dp",  {31'd0, dp},  32'd1);
      chk("rst_an2", {28'd0, an2}, 32'h0);
      chk("rst_seg2", {25'd0, seg2}, 32'h0);
      chk("rst_dp2", {31'd0, dp2}, 32'd0);
      chk_en = 1'b1;
    end

    // First cycle after release still shows the cleared shadow, blanked
    rst = 1'b0;
    tick();
    chk("pre_an",  {28'd0, an},  32'hF);
    chk("pre_seg", {25'd0, seg}, 32'h40);
    chk("pre_dp",  {31'd0, dp},  32'd1);
    run_frame(1, 31, tbl[0].seg, tbl[0].dp, 16'h1234, 4'b0101, 31);

    // Anti-tear: change at cycle 10 only appears in the following frame
    run_frame(0, 31, tbl[0].seg, tbl[0].dp, tbl[1].data, tbl[1].dot, 10);
    run_frame(0, 31, tbl[1].seg, tbl[1].dp, tbl[2].data, tbl[2].dot, 31);

    // Decode sweep, new value driven in the load cycle itself
    for (int i = 2; i < 18; i++) begin
      if (i < 17) run_frame(0, 31, tbl[i].seg, tbl[i].dp, tbl[i+1].data, tbl[i+1].dot, 31);
      else        run_frame(0, 31, tbl[i].seg, tbl[i].dp, tbl[0].data, tbl[0].dot, 31);
    end

    // Mid-frame reset at digit 2, div_cnt 5
    run_frame(0, 20, tbl[0].seg, tbl[0].dp, tbl[0].data, tbl[0].dot, 99);
    rst = 1'b1;
    tick();
    chk("mid_rst_an",  {28'd0, an},  32'hF);
    chk("mid_rst_seg", {25'd0, seg}, 32'h7F);
    chk("mid_rst_dp",  {31'd0, dp},  32'd1);
    tick();
    rst = 1'b0; data = 16'h5678; dot = 4'b1000;
    tick();
    chk("restart_an",  {28'd0, an},  32'hF);
    chk("restart_seg", {25'd0, seg}, 32'h40);
    chk("restart_dp",  {31'd0, dp},  32'd1);
    nxt_d = 16'($urandom);
    nxt_p = 4'($urandom);
    run_frame(1, 31, {7'h12, 7'h02, 7'h78, 7'h00}, 4'b0111, nxt_d, nxt_p, 31);

    // Random frames with random change points inside the frame
    for (int f = 0; f < 1000; f++) begin
      cur_d = nxt_d;
      cur_p = nxt_p;
      nxt_d = 16'($urandom);
      nxt_p = 4'($urandom);
      run_frame(0, 31, exp_seg(cur_d), ~cur_p, nxt_d, nxt_p, int'($urandom_range(0, 31)));
    end

    // Active-high instance without blanking
    rst2 = 1'b0;
    tick();
    chk("ah_first_an",  {28'd0, an2},  32'h1);
    chk("ah_first_seg", {25'd0, seg2}, 32'h3F);
    chk("ah_first_dp",  {31'd0, dp2},  32'd0);
    for (int j = 1; j < 64; j++) begin
      logic [3:0] oh;
      tick();
      oh = 4'b0001 << ((j / 8) % 4);
      chk("ah_an",  {28'd0, an2},  {28'd0, oh});
      chk("ah_seg", {25'd0, seg2}, 32'h7F);
      chk("ah_dp",  {31'd0, dp2},  32'd1);
    end

    chk_en = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
